// File: rtl/halt_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : halt_ctrl
// Brief    : Halt controller closing the loop between CPU status and the
//            five-phase (F,R,X,M,W) generator. Collects halt sources, raises
//            hlt at an instruction boundary (immediately on a phase-sequence
//            error) and records cause, retired count and active cycle count.
//            Optional breakpoint source enabled by macro HALT_CTRL_BKPT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module halt_ctrl #(
    parameter int CNT_W = 32,
    parameter int PC_W  = 32
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [4:0]       phase,
    input  logic             hlt_insn,
    input  logic             ext_halt,
    input  logic [CNT_W-1:0] icount_lim,
    input  logic [PC_W-1:0]  pc,
    input  logic [PC_W-1:0]  bp_addr,
    input  logic             bp_en,
    output logic             hlt,
    output logic             halted,
    output logic [2:0]       cause,
    output logic [CNT_W-1:0] icount,
    output logic [CNT_W-1:0] ccount,
    output logic             err
);

    localparam logic [2:0]       CAUSE_INSN  = 3'd1;
    localparam logic [2:0]       CAUSE_EXT   = 3'd2;
    localparam logic [2:0]       CAUSE_LIMIT = 3'd3;
    localparam logic [2:0]       CAUSE_ERR   = 3'd4;
    localparam logic [2:0]       CAUSE_BKPT  = 3'd5;
    localparam logic [4:0]       PH_F        = 5'b00001;
    localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [4:0]       prev_phase_q, prev_phase_d;
    logic             pend_q, pend_d;
    logic [2:0]       cause_q, cause_d;
    logic             hlt_q, hlt_d;
    logic             halted_q, halted_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] icount_q, icount_d;
    logic [CNT_W-1:0] ccount_q, ccount_d;

    logic             bkpt_hit;
    logic             src_valid;
    logic [2:0]       src_cause;
    logic [4:0]       exp_phase;
    logic             seq_err;
    logic             halt_now;

`ifdef HALT_CTRL_BKPT_EN
    assign bkpt_hit = bp_en && (pc == bp_addr) && phase[0];
`else
    logic unused_bkpt;
    assign bkpt_hit    = 1'b0;
    assign unused_bkpt = ^{pc, bp_addr, bp_en};
`endif

    // The only legal successor of a phase is the next one round the ring (W wraps to F).
    assign exp_phase = {prev_phase_q[3:0], prev_phase_q[4]};

    // Prioritise simultaneous halt sources: instruction > breakpoint > limit > external.
    always_comb begin
        src_valid = 1'b1;
        src_cause = CAUSE_INSN;
        if (hlt_insn && phase[2]) begin
            src_cause = CAUSE_INSN;
        end else if (bkpt_hit) begin
            src_cause = CAUSE_BKPT;
        end else if (phase[4] && (icount_lim != '0) && ((icount_q + CNT_ONE) == icount_lim)) begin
            src_cause = CAUSE_LIMIT;
        end else if (ext_halt) begin
            src_cause = CAUSE_EXT;
        end else begin
            src_valid = 1'b0;
        end
    end

    // Next-state, phase checking, pending capture and counter updates.
    always_comb begin
        state_d      = state_q;
        prev_phase_d = prev_phase_q;
        pend_d       = pend_q;
        cause_d      = cause_q;
        hlt_d        = hlt_q;
        halted_d     = halted_q;
        err_d        = err_q;
        icount_d     = icount_q;
        ccount_d     = ccount_q;
        seq_err      = 1'b0;
        halt_now     = 1'b0;

        if ((state_q != ST_HALTED) && (phase != '0)) begin
            ccount_d = ccount_q + CNT_ONE;
        end

        case (state_q)
            ST_IDLE: begin
                if (phase == PH_F) begin
                    state_d      = ST_RUN;
                    prev_phase_d = phase;
                end else if (phase != '0) begin
                    seq_err = 1'b1;
                end
            end
            ST_RUN, ST_DRAIN: begin
                // Comparing with the rotated previous phase also rejects zero and multi-hot.
                if (phase != exp_phase) begin
                    seq_err = 1'b1;
                end else begin
                    prev_phase_d = phase;
                    // Only the first cause is kept; once draining, new sources are ignored.
                    if ((state_q == ST_RUN) && src_valid) begin
                        pend_d  = 1'b1;
                        cause_d = src_cause;
                        state_d = ST_DRAIN;
                    end
                    // The instruction in W always retires, including the halting one.
                    if (phase[4]) begin
                        icount_d = icount_q + CNT_ONE;
                        halt_now = pend_d;
                    end
                end
            end
            default: begin
            end
        endcase

        // A sequence error overrides any halt source seen in the same cycle.
        if (seq_err) begin
            state_d  = ST_HALTED;
            err_d    = 1'b1;
            hlt_d    = 1'b1;
            halted_d = 1'b1;
            cause_d  = CAUSE_ERR;
        end else if (halt_now) begin
            state_d  = ST_HALTED;
            hlt_d    = 1'b1;
            halted_d = 1'b1;
        end
    end

    // State and status registers, cleared asynchronously.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= ST_IDLE;
            prev_phase_q <= '0;
            pend_q       <= 1'b0;
            cause_q      <= '0;
            hlt_q        <= 1'b0;
            halted_q     <= 1'b0;
            err_q        <= 1'b0;
            icount_q     <= '0;
            ccount_q     <= '0;
        end else begin
            state_q      <= state_d;
            prev_phase_q <= prev_phase_d;
            pend_q       <= pend_d;
            cause_q      <= cause_d;
            hlt_q        <= hlt_d;
            halted_q     <= halted_d;
            err_q        <= err_d;
            icount_q     <= icount_d;
            ccount_q     <= ccount_d;
        end
    end

    assign hlt    = hlt_q;
    assign halted = halted_q;
    assign cause  = cause_q;
    assign icount = icount_q;
    assign ccount = ccount_q;
    assign err    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_halt_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_halt_ctrl
// Brief    : Self-checking bench for halt_ctrl. Directed scenarios plus random
//            phase streams compared cycle by cycle with an instruction-level
//            reference model. Honours HALT_CTRL_BKPT_EN like the design.
// Revision : 1.0 - initial release
// ============================================================================
module tb_halt_ctrl;

    localparam int CNT_W = 32;
    localparam int PC_W  = 32;
`ifdef HALT_CTRL_BKPT_EN
    localparam bit BKPT = 1'b1;
`else
    localparam bit BKPT = 1'b0;
`endif

    logic             clk;
    logic             n_rst;
    logic [4:0]       phase;
    logic             hlt_insn;
    logic             ext_halt;
    logic [CNT_W-1:0] icount_lim;
    logic [PC_W-1:0]  pc;
    logic [PC_W-1:0]  bp_addr;
    logic             bp_en;
    logic             hlt;
    logic             halted;
    logic [2:0]       cause;
    logic [CNT_W-1:0] icount;
    logic [CNT_W-1:0] ccount;
    logic             err;

    halt_ctrl #(.CNT_W(CNT_W), .PC_W(PC_W)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .phase      (phase),
        .hlt_insn   (hlt_insn),
        .ext_halt   (ext_halt),
        .icount_lim (icount_lim),
        .pc         (pc),
        .bp_addr    (bp_addr),
        .bp_en      (bp_en),
        .hlt        (hlt),
        .halted     (halted),
        .cause      (cause),
        .icount     (icount),
        .ccount     (ccount),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: instruction-level view using a phase index 0..4.
    bit               m_run;
    bit               m_halt;
    bit               m_pend;
    bit               m_err;
    logic [2:0]       m_cause;
    logic [CNT_W-1:0] m_icnt;
    logic [CNT_W-1:0] m_ccnt;
    int               m_last;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int ph_idx(input logic [4:0] ph);
        int idx;
        idx = -1;
        if ($countones(ph) == 1) begin
            for (int i = 0; i < 5; i++) begin
                if (ph[i]) idx = i;
            end
        end
        return idx;
    endfunction

    task automatic model_reset();
        m_run   = 1'b0;
        m_halt  = 1'b0;
        m_pend  = 1'b0;
        m_err   = 1'b0;
        m_cause = '0;
        m_icnt  = '0;
        m_ccnt  = '0;
        m_last  = -1;
    endtask

    task automatic model_step();
        int idx;
        int c;
        bit bad;
        if (m_halt) return;
        if (phase != 5'd0) m_ccnt = m_ccnt + 1'b1;
        idx = ph_idx(phase);
        if (!m_run) bad = (phase != 5'd0) && (idx != 0);
        else        bad = (idx < 0) || (idx != (m_last + 1) % 5);
        if (bad) begin
            m_err   = 1'b1;
            m_halt  = 1'b1;
            m_cause = 3'd4;
            return;
        end
        if (!m_run) begin
            if (idx == 0) begin
                m_run  = 1'b1;
                m_last = 0;
            end
            return;
        end
        m_last = idx;
        if (!m_pend) begin
            c = 0;
            if (hlt_insn && idx == 2)                                        c = 1;
            else if (BKPT && bp_en && idx == 0 && pc == bp_addr)             c = 5;
            else if (idx == 4 && icount_lim != 0 && CNT_W'(m_icnt + 1) == icount_lim) c = 3;
            else if (ext_halt)                                               c = 2;
            if (c != 0) begin
                m_pend  = 1'b1;
                m_cause = 3'(c);
            end
        end
        if (idx == 4) begin
            m_icnt = m_icnt + 1'b1;
            if (m_pend) m_halt = 1'b1;
        end
    endtask

    task automatic check_all();
        check_val("hlt",    64'(hlt),    64'(m_halt));
        check_val("halted", 64'(halted), 64'(m_halt));
        check_val("cause",  64'(cause),  64'(m_cause));
        check_val("icount", 64'(icount), 64'(m_icnt));
        check_val("ccount", 64'(ccount), 64'(m_ccnt));
        check_val("err",    64'(err),    64'(m_err));
    endtask

    // One clock: drive on the falling edge, model on the rising edge, check just after.
    task automatic cyc(input logic [4:0] ph, input bit hi, input bit eh);
        @(negedge clk);
        phase    = ph;
        hlt_insn = hi;
        ext_halt = eh;
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        n_rst    = 1'b0;
        phase    = 5'd0;
        hlt_insn = 1'b0;
        ext_halt = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        n_rst = 1'b1;
    endtask

    // One full F..W instruction; hlt_insn at X if hx, ext_halt during phase ehp (-1 none).
    task automatic run_insn(input logic [PC_W-1:0] pcv, input bit hx, input int ehp);
        pc = pcv;
        for (int k = 0; k < 5; k++) begin
            cyc(5'(1 << k), hx && (k == 2), k == ehp);
        end
    endtask

    initial begin
        int g;
        logic [4:0] ph;
        n_rst      = 1'b0;
        phase      = 5'd0;
        hlt_insn   = 1'b0;
        ext_halt   = 1'b0;
        icount_lim = '0;
        pc         = '0;
        bp_addr    = '0;
        bp_en      = 1'b0;
        model_reset();

        // Plain rotation: four instructions, no halts.
        do_reset();
        for (int i = 0; i < 4; i++) run_insn(PC_W'(4 * i), 1'b0, -1);
        check_val("t1_icount", 64'(icount), 64'd4);
        check_val("t1_ccount", 64'(ccount), 64'd20);
        check_val("t1_hlt",    64'(hlt),    64'd0);

        // Halt instruction in X of instruction 3; later phases ignored.
        do_reset();
        run_insn(32'h0, 1'b0, -1);
        run_insn(32'h4, 1'b0, -1);
        run_insn(32'h8, 1'b1, -1);
        check_val("t2_cause",  64'(cause),  64'd1);
        check_val("t2_icount", 64'(icount), 64'd3);
        check_val("t2_halted", 64'(halted), 64'd1);
        run_insn(32'hC, 1'b0, -1);
        check_val("t2_hold",   64'(icount), 64'd3);

        // Retire limit 5 with ext_halt in the same W: limit wins.
        do_reset();
        icount_lim = CNT_W'(5);
        for (int i = 0; i < 4; i++) run_insn(PC_W'(4 * i), 1'b0, -1);
        run_insn(32'h10, 1'b0, 4);
        check_val("t3_cause",  64'(cause),  64'd3);
        check_val("t3_icount", 64'(icount), 64'd5);
        check_val("t3_hlt",    64'(hlt),    64'd1);
        icount_lim = '0;

        // Phase jump R->M.
        do_reset();
        run_insn(32'h0, 1'b0, -1);
        cyc(5'b00001, 1'b0, 1'b0);
        cyc(5'b00010, 1'b0, 1'b0);
        cyc(5'b01000, 1'b0, 1'b0);
        check_val("t4_err",    64'(err),    64'd1);
        check_val("t4_cause",  64'(cause),  64'd4);
        check_val("t4_icount", 64'(icount), 64'd1);

        // Two-hot phase.
        do_reset();
        run_insn(32'h0, 1'b0, -1);
        cyc(5'b00001, 1'b0, 1'b0);
        cyc(5'b00110, 1'b0, 1'b0);
        check_val("t4b_err",   64'(err),    64'd1);
        check_val("t4b_hlt",   64'(hlt),    64'd1);

        // External halt pulsed during R.
        do_reset();
        run_insn(32'h0, 1'b0, -1);
        run_insn(32'h4, 1'b0, 1);
        check_val("t5_cause",  64'(cause),  64'd2);
        check_val("t5_icount", 64'(icount), 64'd2);

        // Reset while draining.
        do_reset();
        run_insn(32'h0, 1'b0, -1);
        cyc(5'b00001, 1'b0, 1'b0);
        cyc(5'b00010, 1'b0, 1'b1);
        cyc(5'b00100, 1'b0, 1'b0);
        do_reset();
        check_val("t5_rst_cause", 64'(cause), 64'd0);
        run_insn(32'h0, 1'b0, -1);

        // Breakpoint at instruction 2 (only effective with the feature built in).
        do_reset();
        bp_en   = 1'b1;
        bp_addr = 32'h10;
        run_insn(32'h0C, 1'b0, -1);
        run_insn(32'h10, 1'b0, -1);
        run_insn(32'h14, 1'b0, -1);
        check_val("t6_icount", 64'(icount), BKPT ? 64'd2 : 64'd3);
        check_val("t6_cause",  64'(cause),  BKPT ? 64'd5 : 64'd0);
        check_val("t6_hlt",    64'(hlt),    BKPT ? 64'd1 : 64'd0);
        bp_en = 1'b0;

        // Random episodes with occasional illegal phases and random halt sources.
        for (int ep = 0; ep < 16; ep++) begin
            do_reset();
            icount_lim = ($urandom_range(0, 2) == 0) ? '0 : CNT_W'($urandom_range(1, 8));
            bp_en      = 1'($urandom_range(0, 1));
            bp_addr    = PC_W'(32'h10 + 4 * $urandom_range(0, 3));
            g = -1;
            for (int t = 0; t < 80; t++) begin
                if (g < 0) begin
                    if ($urandom_range(0, 2) == 0) begin
                        ph = 5'd0;
                    end else begin
                        g  = 0;
                        ph = 5'b00001;
                    end
                end else begin
                    g  = (g + 1) % 5;
                    ph = 5'(1 << g);
                end
                if (g == 0 && ph == 5'b00001) pc = PC_W'(32'h10 + 4 * $urandom_range(0, 3));
                if ($urandom_range(0, 59) == 0) ph = 5'($urandom_range(0, 31));
                cyc(ph, $urandom_range(0, 24) == 0, $urandom_range(0, 39) == 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/halt_ctrl.md
Name: halt_ctrl

Overview:
- Consumer of the one-hot five-phase vector (F,R,X,M,W) and sole producer of the `hlt` input of the phase generator.
- Closes the loop between CPU status and phase sequencing.
- Collects halt sources (halt instruction, external halt request, retire-count limit, phase-sequence error) and asserts `hlt` only at an instruction boundary, except on error.
- Records halt cause, retired-instruction count and cycle count for the test harness.

Parameters:
- CNT_W, 32, width of `icount` and `ccount`.
- PC_W, 32, width of `pc` and `bp_addr`.

Ports:
- clk  input  1  system clock
- n_rst  input  1  asynchronous active-low reset
- phase  input  5  one-hot phase vector; bit0=F, 1=R, 2=X, 3=M, 4=W; 0 = idle
- hlt_insn  input  1  decoded halt opcode, valid while phase[X]
- ext_halt  input  1  level halt request from harness
- icount_lim  input  CNT_W  retire-count limit; 0 = no limit
- pc  input  PC_W  PC of current instruction, stable F..W
- bp_addr  input  PC_W  breakpoint address (BKPT_EN only)
- bp_en  input  1  breakpoint enable (BKPT_EN only)
- hlt  output  1  halt to phase generator
- halted  output  1  controller in HALTED state
- cause  output  3  halt cause code
- icount  output  CNT_W  retired instructions
- ccount  output  CNT_W  cycles with nonzero phase
- err  output  1  phase-sequence error, sticky

Behaviour:
- Reset (n_rst=0, asynchronous): all outputs 0; state IDLE; pending flag cleared; `prev_phase` register = 0.
- States:
  - IDLE: waits for first phase[F].
  - RUN: normal execution.
  - DRAIN: halt pending, waiting for end of W.
  - HALTED: terminal until reset.
- IDLE -> RUN when phase == 5'b00001. Any other nonzero phase in IDLE -> error.
- Phase checker runs in RUN and DRAIN:
  - Legal next phase is `prev_phase` rotated left by one (W->F).
  - `phase` must be one-hot.
  - `phase` == 0 in RUN/DRAIN is an error.
- Error handling: cause=3'd4, err=1, `hlt`=1 on the next edge regardless of phase, state HALTED. Error has priority over every other source in the same cycle.
- Pending halt is set in RUN by:
  - `hlt_insn` sampled while phase[X] (cause 3'd1)
  - `ext_halt` in any phase (cause 3'd2)
  - retire-count match (cause 3'd3)
  - breakpoint (cause 3'd5)
- Cause priority for simultaneous sources: 1 > 5 > 3 > 2. Only the first cause is latched; later sources are ignored.
- RUN with pending -> DRAIN.
- DRAIN: on the edge ending phase[W], `hlt` <= 1, `halted` <= 1, state HALTED. The draining instruction always retires.
- Pending raised during phase[W] itself: takes effect at the same W edge. No extra instruction executes.
- Retire: `icount` increments on every edge ending phase[W], including the halting instruction.
- Retire-count limit: when `icount_lim` != 0 and `icount`+1 == `icount_lim` during phase[W], pending is set with cause 3. Halt occurs at that same edge; `icount` ends equal to the limit.
- `ccount` increments every cycle that `phase` != 0 while not HALTED.
- Both counters wrap modulo 2^CNT_W without flag.
- HALTED: `hlt`, `halted`, `cause`, `err` and counters hold. All inputs are ignored. Exit only by n_rst.
- Reset mid-operation: immediate clear as above; no partial retire counted.

Optional Feature:
- Macro: HALT_CTRL_BKPT_EN.
- Defined:
  - `pc` == `bp_addr` with `bp_en`=1 sampled during phase[F] sets pending with cause 3'd5.
  - The matching instruction completes and the CPU halts after its W phase.
- Undefined:
  - `bp_addr`, `bp_en` and `pc` are unused.
  - Cause 5 is never produced.
  - Ports remain in the port list.

Test Plan:
- Reset then normal phase rotation for 4 instructions, `icount_lim`=0, no halts -> `icount`=4, `ccount`=20, `hlt`=0, `err`=0.
- `hlt_insn`=1 during X of instruction 3 -> `hlt` rises on the edge ending that W, `cause`=1, `icount`=3, `halted`=1; further phases are ignored.
- `icount_lim`=5 -> `hlt` at end of 5th W, `cause`=3, `icount`=5; `ext_halt` asserted in the same cycle still gives `cause`=3.
- Phase jumps R->M (5'b00010 -> 5'b01000) -> next edge `err`=1, `hlt`=1, `cause`=4, no W retire; also two-hot 5'b00110 -> same response.
- `ext_halt` pulsed for 1 cycle during R -> halt at end of that instruction's W, `cause`=2; n_rst pulse in DRAIN -> all outputs 0, state IDLE.
- HALT_CTRL_BKPT_EN defined, `bp_en`=1, `bp_addr`=0x10, `pc`=0x10 at instruction 2 -> halt after its W, `cause`=5, `icount`=2; same run without the macro -> no halt.
